// File: rtl/capture_trigger_ctrl_pkg.sv
// capture_trigger_ctrl_pkg: state encoding shared by the capture trigger controller
package capture_trigger_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;
endpackage

// File: rtl/capture_trigger_ctrl_trig_detect.sv
// trig_detect: previous-sample register and combinational level-crossing flag
module trig_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] sample,
  input  logic [7:0] trig_level,
  input  logic       trig_falling,
  output logic       hit
);
  logic [7:0] prev;
  logic       prev_vld;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (clear) begin
      prev_vld <= 1'b0;
    end else if (load) begin
      prev     <= sample;
      prev_vld <= 1'b1;
    end
  end
  always_comb hit = prev_vld && (trig_falling ? (prev > trig_level && sample <= trig_level)
                                              : (prev < trig_level && sample >= trig_level));
endmodule

// File: rtl/capture_trigger_ctrl.sv
// capture_trigger_ctrl: circular-buffer capture with pre-trigger window, level trigger and auto force
module capture_trigger_ctrl
  import capture_trigger_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int PRETRIG      = 32,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic [7:0]        sample,
  input  logic [7:0]        trig_level,
  input  logic              trig_falling,
  input  logic              auto_mode,
  input  logic              arm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] start_addr,
  output logic              forced
);
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int POST_LEN = DEPTH - PRETRIG;
  localparam int TW       = $clog2(AUTO_TIMEOUT + 2);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W:0]   POST_LAST = (ADDR_W + 1)'(POST_LEN - 1);
  localparam logic [TW-1:0]     T_LAST    = TW'(AUTO_TIMEOUT - 1);
  state_t state, nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   pcnt;
  logic [TW-1:0]     tcnt;
  logic arm_ok, wr, hit, force_ev, fire;
  trig_detect u_trig (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (arm_ok),
    .load         (wr),
    .sample       (sample),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .hit          (hit)
  );
  always_comb begin
    busy     = state == PRE || state == WAIT_TRIG || state == POST;
    done     = state == DONE;
    arm_ok   = arm && !busy;
    wr       = sample_tick && busy;
    force_ev = auto_mode && AUTO_TIMEOUT != 0 && tcnt == T_LAST;
    fire     = wr && state == WAIT_TRIG && (hit || force_ev);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (arm) nxt = (PRETRIG == 0) ? WAIT_TRIG : PRE;
      PRE:        if (wr && ptr == PRE_LAST) nxt = WAIT_TRIG;
      WAIT_TRIG:  if (fire) nxt = (POST_LEN == 1) ? DONE : POST;
      POST:       if (wr && pcnt == POST_LAST) nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end
  // pcnt counts frame samples from the trigger onward, the trigger itself being sample 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      pcnt       <= '0;
      tcnt       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      start_addr <= '0;
      forced     <= 1'b0;
    end else begin
      wr_en <= wr;
      if (arm_ok) begin
        ptr    <= '0;
        tcnt   <= '0;
        forced <= 1'b0;
      end
      if (wr) begin
        ptr     <= ptr + 1'b1;
        wr_addr <= ptr;
        wr_data <= sample;
      end
      if (wr && state == WAIT_TRIG && tcnt != '1) tcnt <= tcnt + 1'b1;
      if (fire) begin
        start_addr <= ptr - PRE_OFS;
        forced     <= !hit;
        pcnt       <= {{ADDR_W{1'b0}}, 1'b1};
      end else if (wr && state == POST) begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// tb_capture_trigger_ctrl: scoreboard bench, directed vectors with hand-computed frames
module tb_capture_trigger_ctrl;
  logic clk = 0, rst_n = 1, sample_tick = 0, trig_falling = 0, auto_mode = 0, arm = 0, arm0 = 0;
  logic [7:0] sample = 0, trig_level = 0;
  logic wr_en, busy, done, forced, wr_en0, busy0, done0, forced0;
  logic [7:0] wr_addr, wr_data, start_addr, wr_addr0, wr_data0, start_addr0;
  int n_chk = 0, n_fail = 0;
  logic [15:0] wq[$];
  logic [8:0]  fq[$];
  logic [16:0] fq0[$];
  logic [15:0] e_w;
  logic [8:0]  e_f;
  logic [16:0] e_f0;
  logic [7:0]  addr_e = 0;
  logic done_q = 0, done0_q = 0;

  always #5 clk = ~clk;

  capture_trigger_ctrl #(.ADDR_W(8), .PRETRIG(32), .AUTO_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .sample(sample),
    .trig_level(trig_level), .trig_falling(trig_falling), .auto_mode(auto_mode), .arm(arm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .start_addr(start_addr), .forced(forced)
  );

  capture_trigger_ctrl #(.ADDR_W(8), .PRETRIG(0), .AUTO_TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .sample(sample),
    .trig_level(trig_level), .trig_falling(trig_falling), .auto_mode(auto_mode), .arm(arm0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0), .done(done0),
    .start_addr(start_addr0), .forced(forced0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    done_q  <= done;
    done0_q <= done0;
    if (wr_en) begin
      if (wq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        e_w = wq.pop_front();
        chk("wr_addr", {24'd0, wr_addr}, {24'd0, e_w[15:8]});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e_w[7:0]});
      end
    end
    if (done && !done_q) begin
      if (fq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: start_addr 0x%0h, expected no frame", start_addr);
      end else begin
        e_f = fq.pop_front();
        chk("start_addr", {24'd0, start_addr}, {24'd0, e_f[7:0]});
        chk("forced", {31'd0, forced}, {31'd0, e_f[8]});
      end
    end
    if (done0 && !done0_q) begin
      if (fq0.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done0: start_addr 0x%0h, expected no frame", start_addr0);
      end else begin
        e_f0 = fq0.pop_front();
        chk("start_addr0", {24'd0, start_addr0}, {24'd0, e_f0[7:0]});
        chk("forced0", {31'd0, forced0}, {31'd0, e_f0[8]});
        chk("last_wr0", {23'd0, wr_en0, wr_addr0, wr_data0},
            {23'd0, 1'b1, e_f0[7:0] - 8'd1, e_f0[16:9]});
      end
    end
  end

  task automatic tick(input logic [7:0] v, input bit exp_w);
    sample = v;
    sample_tick = 1;
    if (exp_w) begin
      wq.push_back({addr_e, v});
      addr_e++;
    end
    @(posedge clk); #1;
    sample_tick = 0;
  endtask

  task automatic arm_pulse(input bit accepted);
    arm = 1;
    @(posedge clk); #1;
    arm = 0;
    if (accepted) addr_e = 0;
  endtask

  task automatic arm0_pulse();
    arm0 = 1;
    @(posedge clk); #1;
    arm0 = 0;
  endtask

  task automatic arm_tick(input logic [7:0] v);
    arm = 1;
    sample_tick = 1;
    sample = v;
    @(posedge clk); #1;
    arm = 0;
    sample_tick = 0;
    addr_e = 0;
  endtask

  task automatic end_frame(input string name);
    tick(8'h55, 0);
    chk({name, "_done"}, {31'd0, done}, 1);
    chk({name, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    #2 rst_n = 0;
    #1 chk("reset_outputs", {4'd0, wr_en, wr_addr, wr_data, busy, done, start_addr, forced}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // rising, ramp from 68 so the trigger lands right after the pre-trigger window
    trig_level = 100; trig_falling = 0; auto_mode = 0;
    arm_pulse(1);
    chk("t1_busy", {31'd0, busy}, 1);
    fq.push_back({1'b0, 8'd0});
    for (int i = 0; i < 256; i++) tick(8'(68 + i), 1);
    end_frame("t1");

    // falling: rising ramp 0..99 first, then 255 downward; trigger on 50 at address 305 mod 256
    trig_level = 50; trig_falling = 1;
    arm_pulse(1);
    chk("rearm_done_clr", {31'd0, done}, 0);
    chk("rearm_busy", {31'd0, busy}, 1);
    fq.push_back({1'b0, 8'd17});
    for (int i = 0; i < 100; i++) tick(8'(i), 1);
    for (int k = 0; k < 429; k++) tick(8'(255 - k), 1);
    end_frame("t2");

    // auto force on the 16th WAIT_TRIG tick (address 47)
    trig_falling = 0; trig_level = 200; auto_mode = 1;
    arm_pulse(1);
    fq.push_back({1'b1, 8'd15});
    for (int i = 0; i < 271; i++) tick(8'd10, 1);
    end_frame("t3");
    chk("t3_forced_held", {31'd0, forced}, 1);

    // real crossing on the force tick wins
    arm_pulse(1);
    chk("rearm_forced_clr", {31'd0, forced}, 0);
    fq.push_back({1'b0, 8'd15});
    for (int i = 0; i < 271; i++) tick(i == 47 ? 8'd200 : 8'd10, 1);
    end_frame("t3b");

    // lap the buffer three times, trigger at overall sample 840 (address 72)
    auto_mode = 0; trig_level = 100;
    arm_pulse(1);
    fq.push_back({1'b0, 8'd40});
    for (int i = 0; i < 1064; i++) tick(i < 840 ? 8'd0 : 8'd100, 1);
    end_frame("t4");

    // PRETRIG=0 instance; second frame checks the first post-arm sample cannot trigger
    arm0_pulse();
    fq0.push_back({8'd0, 1'b0, 8'd10});
    for (int i = 0; i < 266; i++) tick(i == 10 ? 8'd100 : 8'd0, 0);
    tick(8'h55, 0);
    chk("t5a_done0", {31'd0, done0}, 1);
    chk("t5a_busy0", {31'd0, busy0}, 0);
    arm0_pulse();
    fq0.push_back({8'd0, 1'b0, 8'd2});
    for (int i = 0; i < 258; i++) tick(i == 0 ? 8'd150 : (i == 2 ? 8'd100 : 8'd0), 0);
    tick(8'h55, 0);
    chk("t5b_done0", {31'd0, done0}, 1);
    chk("t5b_busy0", {31'd0, busy0}, 0);

    // arm with a tick writes nothing; arms during busy are ignored
    arm_tick(8'd99);
    fq.push_back({1'b0, 8'd10});
    for (int i = 0; i < 20; i++) tick(8'd0, 1);
    arm_pulse(0);
    chk("busy_arm_ignored", {31'd0, busy}, 1);
    for (int i = 0; i < 22; i++) tick(8'd0, 1);
    arm_pulse(0);
    tick(8'd100, 1);
    arm_pulse(0);
    for (int i = 0; i < 223; i++) tick(8'd0, 1);
    end_frame("t6");

    // asynchronous reset mid-POST, then a clean frame
    arm_pulse(1);
    for (int i = 0; i < 37; i++) tick(8'd0, 1);
    tick(8'd100, 1);
    for (int i = 0; i < 50; i++) tick(8'd0, 1);
    #1 rst_n = 0;
    #1 chk("async_rst_outputs", {4'd0, wr_en, wr_addr, wr_data, busy, done, start_addr, forced}, 0);
    wq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_done", {31'd0, done}, 0);
    arm_pulse(1);
    fq.push_back({1'b0, 8'd3});
    for (int i = 0; i < 259; i++) tick(i == 35 ? 8'd100 : 8'd0, 1);
    end_frame("t7");

    chk("wq_empty", wq.size(), 0);
    chk("fq_empty", fq.size(), 0);
    chk("fq0_empty", fq0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/capture_trigger_ctrl.md
# capture_trigger_ctrl

Trigger and acquisition controller for the scope capture RAM. It watches the 8-bit display-scaled sample stream and writes samples into the capture RAM as a circular buffer. It holds a fixed pre-trigger window, detects a level crossing, and stops after the post-trigger window. It then reports the oldest-sample address so the display FSM can replay exactly one trigger-aligned frame.

## Interface
Parameters:
- ADDR_W, 8: capture RAM address width; depth DEPTH = 2**ADDR_W.
- PRETRIG, 32: samples kept before the trigger sample; legal range 0..DEPTH-1.
- AUTO_TIMEOUT, 1024: sample ticks to wait for a trigger in auto mode before forcing one; 0 disables forcing.

Ports:
- clk, in, 1: system clock; the only clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- sample_tick, in, 1: one-cycle strobe, new sample valid on sample.
- sample, in, 8: display-scaled sample.
- trig_level, in, 8: trigger threshold.
- trig_falling, in, 1: 0 selects rising slope, 1 selects falling slope.
- auto_mode, in, 1: 1 enables forced trigger after AUTO_TIMEOUT.
- arm, in, 1: one-cycle request to start a capture.
- wr_en, out, 1: capture RAM write strobe.
- wr_addr, out, ADDR_W: capture RAM write address.
- wr_data, out, 8: capture RAM write data.
- busy, out, 1: capture in progress (states PRE, WAIT_TRIG, POST).
- done, out, 1: frame complete; held high until the next accepted arm.
- start_addr, out, ADDR_W: address of the oldest sample in the frame; valid while done.
- forced, out, 1: the last frame was auto-forced; valid while done.

## Operation
States and transitions:
- IDLE: arm goes to PRE.
- PRE: writes every tick. Goes to WAIT_TRIG once PRETRIG samples have been written. If PRETRIG=0, arm goes straight to WAIT_TRIG.
- WAIT_TRIG: writes every tick. Goes to POST when a tick's sample is a trigger or force event.
- POST: goes to DONE after DEPTH-PRETRIG samples, counting the trigger sample as the first.
- DONE: arm goes to PRE (or WAIT_TRIG if PRETRIG=0) and clears done and forced. There is no automatic re-arm.

Capture rules:
- arm is ignored while busy.
- On an accepted arm, the write pointer resets to 0, the previous-sample register is invalidated, and the timeout counter clears.
- Trigger, rising slope: prev < trig_level and sample >= trig_level.
- Trigger, falling slope: prev > trig_level and sample <= trig_level.
- Trigger requires a valid previous sample. The first sample after arm can never trigger.
- Force: auto_mode=1, AUTO_TIMEOUT≠0, and the timeout counter reaches AUTO_TIMEOUT-1 on a tick in WAIT_TRIG. A real trigger on the same tick wins, so forced stays 0.
- The timeout counter counts ticks only in WAIT_TRIG and saturates.
- The write pointer increments modulo DEPTH on every write. WAIT_TRIG may lap the buffer any number of times.
- start_addr = (trigger address − PRETRIG) mod DEPTH. It is latched on the trigger tick.
- trig_level, trig_falling and auto_mode are sampled live each tick. Software changes them only outside busy.

Reset values:
- All outputs are 0 and the state is IDLE.
- A reset mid-capture abandons the frame. done stays 0.

## Timing
- wr_en, wr_addr and wr_data are registered. wr_en pulses exactly one cycle, the cycle after each sample_tick accepted in PRE, WAIT_TRIG or POST.
- The state updates at the same edge as the registered write.
- done rises in the same cycle as the final write's wr_en.
- busy falls in that same cycle.
- Ticks arriving in IDLE or DONE produce no write.
- An arm coinciding with a sample_tick: the tick is not written and is not used as prev.
- Back-to-back ticks (every cycle) are supported at full rate.

## Structure
- Shared package holds the state encoding constants: IDLE, PRE, WAIT_TRIG, POST, DONE.
- One sub-module, trig_detect: holds the previous-sample register and valid bit, and outputs the combinational crossing flag.
- The FSM, pointer and counters live in capture_trigger_ctrl.

## Test plan
- Rising trigger, PRETRIG=32, ramp 0..255 repeating, level 100:
  - Trigger at the sample of value 100.
  - Exactly 256 writes.
  - start_addr = trigger address − 32.
  - done set, forced=0.
- Falling slope, ramp 255..0, level 50:
  - Trigger on sample 50.
  - A rising-only sequence fed first causes no trigger.
- Auto mode, AUTO_TIMEOUT=16, constant input 10, level 200:
  - Forced on the 16th WAIT_TRIG tick, forced=1.
  - Same tick with a real crossing gives forced=0.
- Long wait that laps the buffer 3 times, then a trigger:
  - wr_addr wraps 255→0.
  - start_addr is correct modulo 256.
  - PRETRIG=0 gives start_addr = trigger address.
- Arm pulses during busy are ignored. An arm coinciding with a tick causes no write. Re-arm from DONE clears done within 1 cycle.
- rst_n asserted asynchronously mid-POST:
  - All outputs go to 0 immediately.
  - The next arm captures a full, correct frame.
